// File: rtl/freq_if.sv
// Measurement request / frequency result bundle between the gate counters and freq_calc.
interface freq_if #(
  parameter int W = 40
);
  logic [W-1:0] Nx;
  logic [W-1:0] Ns;
  logic         meas_valid;
  logic         clr;
  logic [W-1:0] freq_hz;
  logic         freq_valid;
  logic         busy;
  logic         sat;
  logic         div0;
  logic         overrun;

  modport master (
    output Nx, Ns, meas_valid, clr,
    input  freq_hz, freq_valid, busy, sat, div0, overrun
  );

  modport slave (
    input  Nx, Ns, meas_valid, clr,
    output freq_hz, freq_valid, busy, sat, div0, overrun
  );
endinterface

// File: rtl/freq_calc.sv
// Reciprocal frequency calculator: freq_hz = floor(Nx * REF_HZ / Ns) using a serial
// shift-add multiply followed by a serial restoring divide.
//
// state | meaning
// IDLE  | waiting for meas_valid; Ns==0 goes straight to DONE
// MUL   | product = Nx * REF_HZ, one Nx bit per cycle (MSB first), W cycles
// DIV   | product / Ns, one quotient bit per cycle, 72 cycles
// DONE  | one-cycle result pulse, back to IDLE
module freq_calc #(
  parameter int unsigned REF_HZ = 72000000,
  parameter int          W      = 40
) (
  input logic   clk_72MHz,
  input logic   rst_n,
  freq_if.slave bus
);
  localparam int            PW    = 72;
  localparam logic [PW-1:0] REF_W = PW'(REF_HZ);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t        state;
  logic [6:0]    cnt;
  logic [W-1:0]  nx_reg;
  logic [W-1:0]  ns_reg;
  logic [PW-1:0] prod;
  logic [W:0]    rem;
  logic [W-1:0]  freq_hz_r;
  logic          freq_valid_r, busy_r, sat_r, div0_r, overrun_r;

  // The dividend shifts out of prod's top while quotient bits shift in at the bottom,
  // so after the last DIV step prod holds the full 72-bit quotient.
  logic [W+1:0]  r_sh, diff;
  logic          q_bit;
  logic [W:0]    rem_next;
  logic [PW-1:0] q_next;
  logic          q_ovf;

  always_comb begin
    r_sh     = {rem, prod[PW-1]};
    diff     = r_sh - {2'b00, ns_reg};
    q_bit    = ~diff[W+1];
    rem_next = q_bit ? diff[W:0] : r_sh[W:0];
    q_next   = {prod[PW-2:0], q_bit};
    q_ovf    = |q_next[PW-1:W];
  end

  always_ff @(posedge clk_72MHz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      nx_reg       <= '0;
      ns_reg       <= '0;
      prod         <= '0;
      rem          <= '0;
      freq_hz_r    <= '0;
      freq_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      sat_r        <= 1'b0;
      div0_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      freq_valid_r <= 1'b0;
      // A request landing in DONE counts as a collision too; a new event beats clr.
      if (bus.meas_valid && state != IDLE)
        overrun_r <= 1'b1;
      else if (bus.clr)
        overrun_r <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.meas_valid) begin
            if (bus.Ns == '0) begin
              state        <= DONE;
              freq_valid_r <= 1'b1;
              freq_hz_r    <= '1;
              sat_r        <= 1'b1;
              div0_r       <= 1'b1;
            end else begin
              nx_reg <= bus.Nx;
              ns_reg <= bus.Ns;
              prod   <= '0;
              rem    <= '0;
              cnt    <= 7'(W - 1);
              busy_r <= 1'b1;
              state  <= MUL;
            end
          end
        end
        MUL: begin
          prod   <= {prod[PW-2:0], 1'b0} + (nx_reg[W-1] ? REF_W : '0);
          nx_reg <= nx_reg << 1;
          if (cnt == '0) begin
            cnt   <= 7'(PW - 1);
            state <= DIV;
          end else begin
            cnt <= cnt - 7'd1;
          end
        end
        DIV: begin
          prod <= q_next;
          rem  <= rem_next;
          if (cnt == '0) begin
            state        <= DONE;
            busy_r       <= 1'b0;
            freq_valid_r <= 1'b1;
            div0_r       <= 1'b0;
            sat_r        <= q_ovf;
            freq_hz_r    <= q_ovf ? '1 : q_next[W-1:0];
          end else begin
            cnt <= cnt - 7'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.freq_hz    = freq_hz_r;
  assign bus.freq_valid = freq_valid_r;
  assign bus.busy       = busy_r;
  assign bus.sat        = sat_r;
  assign bus.div0       = div0_r;
  assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_freq_calc.sv
// Randomized bench for freq_calc against a wide-integer arithmetic reference model.
module tb_freq_calc;
  localparam int W = 40;
  localparam longint unsigned REF = 72000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0, bad = 0, cyc = 0;

  freq_if #(.W(W)) bus ();

  freq_calc #(.REF_HZ(72000000), .W(W)) dut (
    .clk_72MHz(clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0] >> $urandom_range(0, W - 1);
  endfunction

  function automatic void model(input logic [W-1:0] nx, input logic [W-1:0] ns,
                                output logic [W-1:0] f, output logic s, output logic d);
    logic [127:0] q;
    if (ns == '0) begin
      f = '1; s = 1'b1; d = 1'b1;
    end else begin
      q = (128'(nx) * 128'(REF)) / 128'(ns);
      s = (q >> W) != 128'd0;
      f = s ? '1 : q[W-1:0];
      d = 1'b0;
    end
  endfunction

  task automatic start(input logic [W-1:0] nx, input logic [W-1:0] ns);
    @(negedge clk);
    bus.Nx = nx; bus.Ns = ns; bus.meas_valid = 1'b1;
    cyc = 0;
    tick();
    bus.meas_valid = 1'b0;
    bus.Nx = rand_word();
    bus.Ns = rand_word();
  endtask

  task automatic finish_meas(input logic [W-1:0] nx, input logic [W-1:0] ns, input string tag);
    logic [W-1:0] f;
    logic s, d;
    model(nx, ns, f, s, d);
    while (!bus.freq_valid && cyc < 300) tick();
    check({tag, " latency"}, 64'(cyc), (ns == '0) ? 64'd1 : 64'(W + 73));
    check({tag, " freq_hz"}, 64'(bus.freq_hz), 64'(f));
    check({tag, " sat"}, 64'(bus.sat), 64'(s));
    check({tag, " div0"}, 64'(bus.div0), 64'(d));
    check({tag, " busy_in_done"}, 64'(bus.busy), 64'd0);
    tick();
    check({tag, " pulse_len"}, 64'(bus.freq_valid), 64'd0);
    check({tag, " hold"}, 64'(bus.freq_hz), 64'(f));
  endtask

  initial begin
    logic [W-1:0] n1, s1, n2, s2;
    bus.Nx = '0; bus.Ns = '0; bus.meas_valid = 1'b0; bus.clr = 1'b0;
    repeat (3) tick();
    check("rst freq_hz", 64'(bus.freq_hz), 64'd0);
    check("rst freq_valid", 64'(bus.freq_valid), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst sat", 64'(bus.sat), 64'd0);
    check("rst div0", 64'(bus.div0), 64'd0);
    check("rst overrun", 64'(bus.overrun), 64'd0);
    rst_n = 1'b1;

    start(40'd10000000, 40'd72000000);
    check("busy after capture", 64'(bus.busy), 64'd1);
    finish_meas(40'd10000000, 40'd72000000, "exact10M");
    check("exact10M const", 64'(bus.freq_hz), 64'd10000000);
    start(40'd1, 40'd3);
    finish_meas(40'd1, 40'd3, "1_3");
    check("1_3 const", 64'(bus.freq_hz), 64'd24000000);
    start(40'd7, 40'd2);
    finish_meas(40'd7, 40'd2, "7_2");
    check("7_2 const", 64'(bus.freq_hz), 64'd252000000);
    start('1, 40'd1);
    finish_meas('1, 40'd1, "max_sat");
    check("max_sat const", 64'(bus.sat), 64'd1);
    start(40'd5, 40'd0);
    finish_meas(40'd5, 40'd0, "div0");
    check("div0 const", 64'(bus.freq_hz), 64'hFF_FFFF_FFFF);

    for (int i = 0; i < 24; i++) begin
      n1 = rand_word();
      s1 = ($urandom_range(0, 11) == 0) ? '0 : rand_word();
      start(n1, s1);
      finish_meas(n1, s1, "rand");
    end

    // collision at cycle 50, then clr
    n1 = rand_word(); s1 = rand_word() | 40'd1;
    start(n1, s1);
    while (cyc < 50) tick();
    bus.meas_valid = 1'b1; bus.Nx = rand_word(); bus.Ns = rand_word();
    tick();
    bus.meas_valid = 1'b0;
    check("ovr set", 64'(bus.overrun), 64'd1);
    check("ovr busy", 64'(bus.busy), 64'd1);
    finish_meas(n1, s1, "ovr_run");
    check("ovr sticky", 64'(bus.overrun), 64'd1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("ovr clr", 64'(bus.overrun), 64'd0);

    // request in the DONE cycle is ignored
    n1 = rand_word(); s1 = rand_word() | 40'd1;
    start(n1, s1);
    while (!bus.freq_valid && cyc < 300) tick();
    check("done latency", 64'(cyc), 64'(W + 73));
    bus.meas_valid = 1'b1; bus.Nx = rand_word(); bus.Ns = rand_word() | 40'd1;
    tick();
    bus.meas_valid = 1'b0;
    check("done ovr", 64'(bus.overrun), 64'd1);
    check("done ignored", 64'(bus.busy), 64'd0);
    tick();
    check("done still idle", 64'(bus.busy), 64'd0);

    // clr together with a new collision keeps overrun set
    n1 = rand_word(); s1 = rand_word() | 40'd1;
    start(n1, s1);
    while (cyc < 30) tick();
    bus.meas_valid = 1'b1; bus.clr = 1'b1;
    tick();
    bus.meas_valid = 1'b0; bus.clr = 1'b0;
    check("clr+event", 64'(bus.overrun), 64'd1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("clr alone", 64'(bus.overrun), 64'd0);
    finish_meas(n1, s1, "clr_run");

    // reset mid-run, then a request in the first cycle after release
    n1 = rand_word(); s1 = rand_word() | 40'd1;
    start(n1, s1);
    while (cyc < 55) tick();
    bus.meas_valid = 1'b1;
    tick();
    bus.meas_valid = 1'b0;
    while (cyc < 60) tick();
    rst_n = 1'b0;
    tick();
    check("mid rst freq_hz", 64'(bus.freq_hz), 64'd0);
    check("mid rst valid", 64'(bus.freq_valid), 64'd0);
    check("mid rst busy", 64'(bus.busy), 64'd0);
    check("mid rst sat", 64'(bus.sat), 64'd0);
    check("mid rst div0", 64'(bus.div0), 64'd0);
    check("mid rst overrun", 64'(bus.overrun), 64'd0);
    tick();
    n2 = rand_word(); s2 = rand_word() | 40'd1;
    rst_n = 1'b1;
    bus.Nx = n2; bus.Ns = s2; bus.meas_valid = 1'b1;
    cyc = 0;
    tick();
    bus.meas_valid = 1'b0;
    bus.Nx = rand_word(); bus.Ns = rand_word();
    finish_meas(n2, s2, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
